// File: rtl/ln_mcif_rd_arb.sv
// Two-requester round-robin read arbiter onto one MCIF read port. An in-order tag FIFO
// records the owner and burst length of each command so response beats are steered back.
module ln_mcif_rd_arb #(
    parameter int LEN_W = 8,
    parameter int PD_W  = LEN_W + 64,
    parameter int DAT_W = 256,
    parameter int OUTS  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_vld,
    output logic                   req0_rdy,
    input  logic [PD_W-1:0]        req0_pd,
    input  logic                   req1_vld,
    output logic                   req1_rdy,
    input  logic [PD_W-1:0]        req1_pd,
    output logic                   mcif_req_vld,
    input  logic                   mcif_req_rdy,
    output logic [PD_W-1:0]        mcif_req_pd,
    input  logic                   mcif_resp_vld,
    output logic                   mcif_resp_rdy,
    input  logic [DAT_W-1:0]       mcif_resp_pd,
    output logic                   resp0_vld,
    input  logic                   resp0_rdy,
    output logic [DAT_W-1:0]       resp0_pd,
    output logic                   resp1_vld,
    input  logic                   resp1_rdy,
    output logic [DAT_W-1:0]       resp1_pd,
    output logic [$clog2(OUTS):0]  outstanding,
    output logic                   idle,
    output logic                   err_orphan
);

    localparam int AW = $clog2(OUTS);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(OUTS);

    logic             last_q, last_d;
    logic             lock_q, lock_d;
    logic             lock_id_q, lock_id_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0] bcnt_q, bcnt_d;
    logic             err_q, err_d;
    logic             id_q  [OUTS];
    logic             id_d  [OUTS];
    logic [LEN_W-1:0] len_q [OUTS];
    logic [LEN_W-1:0] len_d [OUTS];

    logic             fifo_full, fifo_empty;
    logic             sel, sel_vld;
    logic [PD_W-1:0]  sel_pd;
    logic             cmd_hs, resp_hs, pop;
    logic             hid;
    logic [LEN_W-1:0] hlen;

    // Command selection; a stalled command keeps its owner so the payload stays stable.
    always_comb begin
        fifo_full  = (cnt_q == CNT_FULL);
        fifo_empty = (cnt_q == '0);
        if (lock_q) begin
            sel     = lock_id_q;
            sel_vld = lock_id_q ? req1_vld : req0_vld;
        end else begin
            sel_vld = req0_vld | req1_vld;
            sel     = (req0_vld & req1_vld) ? ~last_q : req1_vld;
        end
        sel_pd       = sel ? req1_pd : req0_pd;
        mcif_req_vld = sel_vld & ~fifo_full;
        mcif_req_pd  = sel_pd;
        req0_rdy     = mcif_req_rdy & ~fifo_full & ~sel;
        req1_rdy     = mcif_req_rdy & ~fifo_full & sel;
        cmd_hs       = mcif_req_vld & mcif_req_rdy;
    end

    // Response steering from the FIFO head.
    always_comb begin
        hid           = id_q[rptr_q];
        hlen          = len_q[rptr_q];
        resp0_vld     = mcif_resp_vld & ~fifo_empty & ~hid;
        resp1_vld     = mcif_resp_vld & ~fifo_empty & hid;
        resp0_pd      = mcif_resp_pd;
        resp1_pd      = mcif_resp_pd;
        mcif_resp_rdy = ~fifo_empty & (hid ? resp1_rdy : resp0_rdy);
        resp_hs       = mcif_resp_vld & mcif_resp_rdy;
        pop           = resp_hs & (bcnt_q == hlen);
        outstanding   = cnt_q;
        idle          = ~req0_vld & ~req1_vld & fifo_empty & ~lock_q;
        err_orphan    = err_q;
    end

    always_comb begin
        last_d    = last_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        bcnt_d    = bcnt_q;
        err_d     = err_q | (mcif_resp_vld & fifo_empty);
        id_d      = id_q;
        len_d     = len_q;

        if (mcif_req_vld & ~mcif_req_rdy) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end else if (cmd_hs) begin
            lock_d = 1'b0;
        end

        if (cmd_hs) begin
            id_d[wptr_d]  = sel;
            len_d[wptr_d] = sel_pd[64 +: LEN_W];
            wptr_d        = wptr_q + 1'b1;
            last_d        = sel;
        end

        if (resp_hs) begin
            if (pop) begin
                bcnt_d = '0;
                rptr_d = rptr_q + 1'b1;
            end else begin
                bcnt_d = bcnt_q + LEN_W'(1);
            end
        end

        if (cmd_hs & ~pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop & ~cmd_hs) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= 1'b1;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < OUTS; i++) begin
                id_q[i]  <= 1'b0;
                len_q[i] <= '0;
            end
        end else begin
            last_q    <= last_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            err_q     <= err_d;
            id_q      <= id_d;
            len_q     <= len_d;
        end
    end

endmodule

// File: tb/tb_ln_mcif_rd_arb.sv
// Directed self-checking bench for ln_mcif_rd_arb; inputs change and outputs are
// sampled around the falling clock edge.
module tb_ln_mcif_rd_arb;

    localparam int LEN_W = 8;
    localparam int PD_W  = LEN_W + 64;
    localparam int DAT_W = 256;
    localparam int OUTS  = 8;

    logic              clk;
    logic              rst;
    logic              req0_vld, req0_rdy, req1_vld, req1_rdy;
    logic [PD_W-1:0]   req0_pd, req1_pd, mcif_req_pd;
    logic              mcif_req_vld, mcif_req_rdy;
    logic              mcif_resp_vld, mcif_resp_rdy;
    logic [DAT_W-1:0]  mcif_resp_pd, resp0_pd, resp1_pd;
    logic              resp0_vld, resp0_rdy, resp1_vld, resp1_rdy;
    logic [3:0]        outstanding;
    logic              idle, err_orphan;

    int n_cmp = 0;
    int n_bad = 0;

    ln_mcif_rd_arb #(
        .LEN_W(LEN_W),
        .PD_W (PD_W),
        .DAT_W(DAT_W),
        .OUTS (OUTS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_vld     (req0_vld),
        .req0_rdy     (req0_rdy),
        .req0_pd      (req0_pd),
        .req1_vld     (req1_vld),
        .req1_rdy     (req1_rdy),
        .req1_pd      (req1_pd),
        .mcif_req_vld (mcif_req_vld),
        .mcif_req_rdy (mcif_req_rdy),
        .mcif_req_pd  (mcif_req_pd),
        .mcif_resp_vld(mcif_resp_vld),
        .mcif_resp_rdy(mcif_resp_rdy),
        .mcif_resp_pd (mcif_resp_pd),
        .resp0_vld    (resp0_vld),
        .resp0_rdy    (resp0_rdy),
        .resp0_pd     (resp0_pd),
        .resp1_vld    (resp1_vld),
        .resp1_rdy    (resp1_rdy),
        .resp1_pd     (resp1_pd),
        .outstanding  (outstanding),
        .idle         (idle),
        .err_orphan   (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PD_W-1:0] mk_pd(input logic [LEN_W-1:0] len, input logic [63:0] a);
        return {len, a};
    endfunction

    task automatic clear_inputs();
        req0_vld = 0; req1_vld = 0; req0_pd = '0; req1_pd = '0;
        mcif_req_rdy = 0; mcif_resp_vld = 0; mcif_resp_pd = '0;
        resp0_rdy = 1; resp1_rdy = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    bit exp_id  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    bit r1_rdy  [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    bit exp_mrd [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};

    initial begin
        logic [DAT_W-1:0] d;
        rst = 1;
        clear_inputs();
        resp0_rdy = 0; resp1_rdy = 0;
        #2;
        check("rst_outstanding", 256'(outstanding), 0);
        check("rst_idle", 256'(idle), 1);
        check("rst_err", 256'(err_orphan), 0);
        check("rst_mreq_vld", 256'(mcif_req_vld), 0);
        check("rst_req0_rdy", 256'(req0_rdy), 0);
        check("rst_mresp_rdy", 256'(mcif_resp_rdy), 0);
        check("rst_resp0_vld", 256'(resp0_vld), 0);
        @(negedge clk);
        rst = 0;

        // Single request, len=3 -> 4 beats to resp0.
        @(negedge clk);
        resp0_rdy = 1; resp1_rdy = 1;
        req0_vld = 1; req0_pd = mk_pd(3, 64'h1000); mcif_req_rdy = 1;
        #1;
        check("t1_mreq_vld", 256'(mcif_req_vld), 1);
        check("t1_mreq_pd", 256'(mcif_req_pd), 256'(mk_pd(3, 64'h1000)));
        check("t1_req0_rdy", 256'(req0_rdy), 1);
        check("t1_idle_busy", 256'(idle), 0);
        @(negedge clk);
        req0_vld = 0;
        #1;
        check("t1_outstanding", 256'(outstanding), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mcif_resp_vld = 1; mcif_resp_pd = 256'(32'h100 + i);
            #1;
            check("t1_resp0_vld", 256'(resp0_vld), 1);
            check("t1_resp1_vld", 256'(resp1_vld), 0);
            check("t1_resp0_pd", resp0_pd, 256'(32'h100 + i));
            check("t1_mresp_rdy", 256'(mcif_resp_rdy), 1);
            check("t1_outst_beat", 256'(outstanding), 1);
        end
        @(negedge clk);
        mcif_resp_vld = 0;
        #1;
        check("t1_popped", 256'(outstanding), 0);
        check("t1_idle", 256'(idle), 1);

        // Round-robin with both requesters continuously valid.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req0_vld = 1; req0_pd = mk_pd(0, 64'hA0);
                req1_vld = 1; req1_pd = mk_pd(0, 64'hB0);
                mcif_req_rdy = 1;
            end
            #1;
            check("rr_req0_rdy", 256'(req0_rdy), 256'(k % 2 == 0));
            check("rr_req1_rdy", 256'(req1_rdy), 256'(k % 2 == 1));
            check("rr_pd", 256'(mcif_req_pd),
                  256'((k % 2 == 0) ? mk_pd(0, 64'hA0) : mk_pd(0, 64'hB0)));
        end
        @(negedge clk);
        req0_vld = 0; req1_vld = 0;
        #1;
        check("rr_outstanding", 256'(outstanding), 4);

        // Lock: req1 stalled, req0 arrives later but cannot steal the grant.
        do_reset();
        @(negedge clk);
        req1_vld = 1; req1_pd = mk_pd(2, 64'hB100); mcif_req_rdy = 0;
        #1;
        check("lk_mreq_vld", 256'(mcif_req_vld), 1);
        check("lk_pd_c1", 256'(mcif_req_pd), 256'(mk_pd(2, 64'hB100)));
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            req0_vld = 1; req0_pd = mk_pd(1, 64'hA100);
            #1;
            check("lk_pd_hold", 256'(mcif_req_pd), 256'(mk_pd(2, 64'hB100)));
        end
        @(negedge clk);
        mcif_req_rdy = 1;
        #1;
        check("lk_req1_rdy", 256'(req1_rdy), 1);
        check("lk_req0_wait", 256'(req0_rdy), 0);
        @(negedge clk);
        req1_vld = 0;
        #1;
        check("lk_req0_next", 256'(req0_rdy), 1);
        check("lk_pd0", 256'(mcif_req_pd), 256'(mk_pd(1, 64'hA100)));
        @(negedge clk);
        req0_vld = 0;
        #1;
        check("lk_outstanding", 256'(outstanding), 2);

        // Full FIFO: eight len=0 commands, ninth waits for a pop.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req0_vld = 1; req0_pd = mk_pd(0, 64'hC000); mcif_req_rdy = 1;
            end
            #1;
            check("ff_fill", 256'(outstanding), 256'(k));
        end
        @(negedge clk);
        #1;
        check("ff_outst8", 256'(outstanding), 8);
        check("ff_mreq_blk", 256'(mcif_req_vld), 0);
        check("ff_req0_blk", 256'(req0_rdy), 0);
        @(negedge clk);
        mcif_resp_vld = 1; mcif_resp_pd = 256'(32'h55);
        #1;
        check("ff_mresp_rdy", 256'(mcif_resp_rdy), 1);
        check("ff_still_blk", 256'(mcif_req_vld), 0);
        @(negedge clk);
        mcif_resp_vld = 0;
        #1;
        check("ff_outst7", 256'(outstanding), 7);
        check("ff_ninth_vld", 256'(mcif_req_vld), 1);
        check("ff_ninth_rdy", 256'(req0_rdy), 1);
        @(negedge clk);
        req0_vld = 0;
        #1;
        check("ff_refill", 256'(outstanding), 8);

        // Interleaved ownership A(req0,len1) B(req1,len2) C(req0,len0).
        do_reset();
        @(negedge clk);
        req0_vld = 1; req0_pd = mk_pd(1, 64'hA00); mcif_req_rdy = 1;
        #1;
        check("il_a_rdy", 256'(req0_rdy), 1);
        @(negedge clk);
        req0_vld = 0; req1_vld = 1; req1_pd = mk_pd(2, 64'hB00);
        #1;
        check("il_b_rdy", 256'(req1_rdy), 1);
        @(negedge clk);
        req1_vld = 0; req0_vld = 1; req0_pd = mk_pd(0, 64'hC00);
        #1;
        check("il_c_rdy", 256'(req0_rdy), 1);
        @(negedge clk);
        req0_vld = 0;
        #1;
        check("il_outst3", 256'(outstanding), 3);
        d = 256'(1);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            resp1_rdy = r1_rdy[c]; mcif_resp_vld = 1; mcif_resp_pd = d;
            #1;
            check("il_resp0_vld", 256'(resp0_vld), 256'(!exp_id[c]));
            check("il_resp1_vld", 256'(resp1_vld), 256'(exp_id[c]));
            check("il_mresp_rdy", 256'(mcif_resp_rdy), 256'(exp_mrd[c]));
            check("il_data", exp_id[c] ? resp1_pd : resp0_pd, d);
            if (exp_mrd[c]) d = d + 1;
        end
        @(negedge clk);
        mcif_resp_vld = 0; resp1_rdy = 1;
        #1;
        check("il_drained", 256'(outstanding), 0);
        check("il_idle", 256'(idle), 1);
        check("il_no_err", 256'(err_orphan), 0);

        // Orphan beat with an empty FIFO.
        @(negedge clk);
        mcif_resp_vld = 1; mcif_resp_pd = 256'(32'hDEAD);
        #1;
        check("or_mresp_rdy", 256'(mcif_resp_rdy), 0);
        check("or_resp0_vld", 256'(resp0_vld), 0);
        check("or_err_pre", 256'(err_orphan), 0);
        @(negedge clk);
        mcif_resp_vld = 0;
        #1;
        check("or_err_set", 256'(err_orphan), 1);
        @(negedge clk);
        req0_vld = 1; req0_pd = mk_pd(3, 64'hE000); mcif_req_rdy = 1;
        @(negedge clk);
        req0_vld = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mcif_resp_vld = 1; mcif_resp_pd = 256'(32'hE0 + i);
            #1;
            check("or_burst_vld", 256'(resp0_vld), 1);
        end
        check("or_err_sticky", 256'(err_orphan), 1);
        check("or_mid_outst", 256'(outstanding), 1);

        // Reset mid-burst clears state without a clock edge.
        @(negedge clk);
        rst = 1;
        #1;
        check("mr_outstanding", 256'(outstanding), 0);
        check("mr_err", 256'(err_orphan), 0);
        check("mr_mresp_rdy", 256'(mcif_resp_rdy), 0);
        check("mr_idle", 256'(idle), 1);
        check("mr_resp0_vld", 256'(resp0_vld), 0);
        @(negedge clk);
        rst = 0;
        #1;
        check("mr_err_hold0", 256'(err_orphan), 0);
        @(negedge clk);
        #1;
        check("mr_err_inflight", 256'(err_orphan), 1);
        mcif_resp_vld = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
